// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, request field encodings and sizing helper for the memory cycle sequencer
package mem_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STS_WAIT,
        ST_ACCESS,
        ST_HOLD,
        ST_RECOVER,
        ST_ERR
    } state_t;

    localparam logic CHIP_RAM = 1'b0;
    localparam logic CHIP_ROM = 1'b1;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    localparam logic LEN_BYTE = 1'b0;
    localparam logic LEN_WORD = 1'b1;

    function automatic int wait_cnt_width(input int ram_wait, input int rom_wait);
        return $clog2((ram_wait > rom_wait ? ram_wait : rom_wait) + 1);
    endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter timing the access phase
//   clk, rst       clock and synchronous active-high reset
//   load, load_val load the count (takes priority over dec)
//   dec            decrement by one
//   done           count == 1, i.e. this is the last access cycle
module mem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (dec) count <= count - 1'b1;
    end

    assign done = count == WIDTH'(1);
endmodule

// File: rtl/mem_cycle_sequencer.sv
// mem_cycle_sequencer: expands single-cycle requests into sequenced async PSRAM/flash cycles
//   req_*        request port; req_ready is high only while idle
//   rsp_*        one-cycle completion pulse with error flag and read data
//   mem_addr     word address, mem_dout/mem_dout_en write data and pad enable
//   mem_din      read data from pad, mem_rom_sts flash ready status
//   mem_*_n      active-low chip enables, output/write enables and byte lanes
module mem_cycle_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int ADDRESS_SIZE = 24,
    parameter int DATA_SIZE    = 16,
    parameter int RAM_WAIT     = 6,
    parameter int ROM_WAIT     = 12,
    parameter int TURN         = 1,
    parameter int ROM_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    input  logic                    req_chip,
    input  logic                    req_len,
    input  logic                    req_op,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_SIZE-1:0]    rsp_rdata,
    output logic [ADDRESS_SIZE-2:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_dout,
    output logic                    mem_dout_en,
    input  logic [DATA_SIZE-1:0]    mem_din,
    output logic                    mem_ram_ce_n,
    output logic                    mem_rom_ce_n,
    output logic                    mem_oe_n,
    output logic                    mem_we_n,
    output logic                    mem_lb_n,
    output logic                    mem_ub_n,
    input  logic                    mem_rom_sts
);
    localparam int WW = wait_cnt_width(RAM_WAIT, ROM_WAIT);
    localparam int TW = $clog2(TURN + 1);

    state_t state, state_nx;
    logic chip_q, op_q, len_q, odd_q;
    logic chip_d, op_d, len_d, odd_d;
    logic [7:0] tcnt;
    logic [TW-1:0] rcnt;
    logic [DATA_SIZE-1:0] rdata_q;
    logic accept, wait_load, wait_done, in_cyc, first_rsp;

    assign req_ready = state == ST_IDLE && !rst;
    assign accept = req_valid && req_ready;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (accept) state_nx = (req_chip == CHIP_ROM && req_op == OP_WRITE) ? ST_ERR : ST_SETUP;
            ST_SETUP:    state_nx = (chip_q == CHIP_ROM && op_q == OP_READ && !mem_rom_sts) ? ST_STS_WAIT : ST_ACCESS;
            ST_STS_WAIT: state_nx = mem_rom_sts ? ST_ACCESS : tcnt == 8'(ROM_TIMEOUT - 1) ? ST_RECOVER : ST_STS_WAIT;
            ST_ACCESS:   if (wait_done) state_nx = ST_HOLD;
            ST_HOLD:     state_nx = ST_RECOVER;
            ST_RECOVER:  if (rcnt == TW'(TURN - 1)) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the request fields must be
    // taken from the port in the accepting cycle and from the latches afterwards.
    assign chip_d = accept ? req_chip : chip_q;
    assign op_d   = accept ? req_op : op_q;
    assign len_d  = accept ? req_len : len_q;
    assign odd_d  = accept ? req_addr[0] : odd_q;
    assign in_cyc = state_nx inside {ST_SETUP, ST_STS_WAIT, ST_ACCESS, ST_HOLD};
    assign first_rsp = state_nx == ST_RECOVER && state != ST_RECOVER;
    assign wait_load = state_nx == ST_ACCESS && state != ST_ACCESS;

    mem_wait_counter #(.WIDTH(WW)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .dec      (state == ST_ACCESS),
        .load_val (chip_q == CHIP_ROM ? WW'(ROM_WAIT) : WW'(RAM_WAIT)),
        .done     (wait_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            {chip_q, op_q, len_q, odd_q} <= '0;
            tcnt         <= '0;
            rcnt         <= '0;
            rdata_q      <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            mem_addr     <= '0;
            mem_dout     <= '0;
            mem_dout_en  <= 1'b0;
            mem_ram_ce_n <= 1'b1;
            mem_rom_ce_n <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_lb_n     <= 1'b1;
            mem_ub_n     <= 1'b1;
        end else begin
            state <= state_nx;
            if (accept) begin
                {chip_q, op_q, len_q, odd_q} <= {req_chip, req_op, req_len, req_addr[0]};
                mem_addr <= req_addr[ADDRESS_SIZE-1:1];
                mem_dout <= req_len == LEN_WORD ? req_wdata : {2{req_wdata[7:0]}};
            end
            tcnt <= state == ST_STS_WAIT ? tcnt + 1'b1 : '0;
            rcnt <= state == ST_RECOVER ? rcnt + 1'b1 : '0;
            if (state == ST_ACCESS && wait_done)
                rdata_q <= len_q == LEN_WORD ? mem_din : DATA_SIZE'(odd_q ? mem_din[15:8] : mem_din[7:0]);
            // Publish read data together with the response so it stays stable until the next read.
            if (state == ST_HOLD && op_q == OP_READ) rsp_rdata <= rdata_q;
            rsp_valid    <= first_rsp || state_nx == ST_ERR;
            // RECOVER entered straight from STS_WAIT only happens on a status timeout.
            rsp_err      <= state_nx == ST_ERR || (first_rsp && state == ST_STS_WAIT);
            mem_dout_en  <= in_cyc && op_d == OP_WRITE;
            mem_ram_ce_n <= !(in_cyc && chip_d == CHIP_RAM);
            mem_rom_ce_n <= !(in_cyc && chip_d == CHIP_ROM);
            mem_oe_n     <= !(state_nx == ST_ACCESS && op_d == OP_READ);
            mem_we_n     <= !(state_nx == ST_ACCESS && op_d == OP_WRITE);
            mem_lb_n     <= !(in_cyc && (len_d == LEN_WORD || !odd_d));
            mem_ub_n     <= !(in_cyc && (len_d == LEN_WORD || odd_d));
        end
    end
endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// tb_mem_cycle_sequencer: directed self-checking bench with a cycle-timeline model of the sequencer
module tb_mem_cycle_sequencer;
    localparam int RAM_WAIT = 6, ROM_WAIT = 12, TURN = 1, ROM_TIMEOUT = 255;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_chip = 1'b0, req_len = 1'b0, req_op = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic rsp_valid, rsp_err;
    logic [15:0] rsp_rdata, mem_dout;
    logic [15:0] mem_din = '0;
    logic [22:0] mem_addr;
    logic mem_dout_en, mem_ram_ce_n, mem_rom_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
    logic mem_rom_sts = 1'b1;

    always #5 clk = ~clk;

    mem_cycle_sequencer #(
        .ADDRESS_SIZE(24), .DATA_SIZE(16), .RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT),
        .TURN(TURN), .ROM_TIMEOUT(ROM_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_chip(req_chip), .req_len(req_len), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_dout_en(mem_dout_en), .mem_din(mem_din),
        .mem_ram_ce_n(mem_ram_ce_n), .mem_rom_ce_n(mem_rom_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n), .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n), .mem_rom_sts(mem_rom_sts)
    );

    int cyc = 0;
    logic prev_rst = 1'b1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_rst <= rst;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction timeline: acceptance cycle and the derived phase boundaries.
    bit t_act = 0, t_chip = 0, t_op = 0, t_len = 0, t_odd = 0, t_to = 0;
    int t_a = 0, t_k = 0, t_ss = -1, t_ae = -1, t_hd = -1, t_rv = -1, t_idle = 0;
    logic [23:0] t_addr = '0;
    logic [15:0] t_wd = '0, t_din = '0, exp_rdata = '0;
    int we_cnt, oe_cnt, ce_cnt, first_oe, rv_off, ready_off;
    logic rv_err;
    logic [15:0] rv_data;

    // Memory/flash behaviour: status low for t_k cycles from SETUP, data valid only in the last access cycle.
    always @(posedge clk) begin
        #2;
        mem_rom_sts = !(t_act && cyc >= t_a + 1 && cyc <= t_a + t_k);
        mem_din = (t_act && cyc == t_ae) ? t_din : ~t_din;
    end

    always @(negedge clk) begin
        logic [9:0] e, g;
        bit inc;
        if (cyc >= 1) begin
            g = {req_ready, rsp_valid, rsp_err, mem_ram_ce_n, mem_rom_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n, mem_dout_en};
            if (prev_rst) begin
                exp_rdata = '0;
                chk("reset_outputs", 32'(g), 32'({!rst, 9'b001111110}));
                chk("reset_addr", 32'(mem_addr), 0);
                chk("reset_dout", 32'(mem_dout), 0);
                chk("reset_rdata", 32'(rsp_rdata), 0);
            end else if (rst) begin
                chk("ready_in_reset", 32'(req_ready), 0);
            end else begin
                e = 10'b1001111110;
                inc = 0;
                if (t_act && cyc > t_a && cyc < t_idle) begin
                    e[9] = 1'b0;
                    if (cyc <= t_hd) begin
                        inc = 1;
                        if (t_chip) e[5] = 1'b0; else e[6] = 1'b0;
                        e[2] = !(t_len || !t_odd);
                        e[1] = !(t_len || t_odd);
                        e[0] = t_op;
                    end
                    if (cyc >= t_ss && cyc <= t_ae) begin
                        if (t_op) e[3] = 1'b0; else e[4] = 1'b0;
                    end
                    if (cyc == t_rv) begin
                        e[8] = 1'b1;
                        e[7] = t_to || (t_chip && t_op);
                        if (!e[7] && !t_op)
                            exp_rdata = t_len ? t_din : (t_odd ? {8'h00, t_din[15:8]} : {8'h00, t_din[7:0]});
                    end
                end
                chk("strobes", 32'(g), 32'(e));
                chk("rdata", 32'(rsp_rdata), 32'(exp_rdata));
                if (inc) begin
                    chk("addr", 32'(mem_addr), 32'(t_addr[23:1]));
                    if (t_op) chk("dout", 32'(mem_dout), 32'(t_len ? t_wd : {2{t_wd[7:0]}}));
                end
            end
            if (t_act) begin
                if (!mem_we_n) we_cnt++;
                if (!mem_oe_n) oe_cnt++;
                if (!mem_ram_ce_n || !mem_rom_ce_n) ce_cnt++;
                if (!mem_oe_n && first_oe < 0) first_oe = cyc - t_a;
                if (rsp_valid) begin
                    rv_off = cyc - t_a;
                    rv_err = rsp_err;
                    rv_data = rsp_rdata;
                end
                if (rv_off >= 0 && req_ready && ready_off < 0) ready_off = cyc - t_a;
            end
        end
    end

    task automatic issue(input bit ch, input bit op, input bit ln, input logic [23:0] ad,
                         input logic [15:0] wd, input logic [15:0] dn, input int k);
        int n = 0;
        int w;
        while (!req_ready && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_issue", 32'(req_ready), 1);
        w = ch ? ROM_WAIT : RAM_WAIT;
        t_a = cyc; t_k = k; t_chip = ch; t_op = op; t_len = ln; t_odd = ad[0];
        t_addr = ad; t_wd = wd; t_din = dn;
        t_to = ch && !op && k > ROM_TIMEOUT;
        if (ch && op) begin
            t_ss = -1; t_ae = -1; t_hd = -1; t_rv = t_a + 1; t_idle = t_a + 2;
        end else if (t_to) begin
            t_ss = -1; t_ae = -1; t_hd = t_a + 1 + ROM_TIMEOUT; t_rv = t_hd + 1; t_idle = t_rv + TURN;
        end else begin
            t_ss = t_a + 2 + ((ch && !op) ? k : 0);
            t_ae = t_ss + w - 1; t_hd = t_ae + 1; t_rv = t_hd + 1; t_idle = t_rv + TURN;
        end
        we_cnt = 0; oe_cnt = 0; ce_cnt = 0; first_oe = -1; rv_off = -1; ready_off = -1;
        rv_err = 1'b0; rv_data = '0;
        t_act = 1;
        req_chip = ch; req_op = op; req_len = ln; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic finish_txn();
        repeat (t_idle - t_a) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_low", 32'(req_ready), 0);
        chk("rst_ce_high", 32'({mem_ram_ce_n, mem_rom_ce_n}), 'b11);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(req_ready), 1);

        issue(0, 1, 1, 24'h000010, 16'hBEEF, 16'h0000, 0);
        finish_txn();
        chk("t1_we_cycles", 32'(we_cnt), 6);
        chk("t1_rsp_cycle", 32'(rv_off), 9);
        chk("t1_rsp_err", 32'(rv_err), 0);
        chk("t1_ready_cycle", 32'(ready_off), 10);

        issue(0, 0, 0, 24'h000011, 16'h0000, 16'hBEEF, 0);
        finish_txn();
        chk("t2_rdata", 32'(rv_data), 'h00BE);
        chk("t2_rsp_cycle", 32'(rv_off), 9);

        issue(1, 0, 1, 24'h000100, 16'h0000, 16'h1234, 5);
        finish_txn();
        chk("t3_oe_start", 32'(first_oe), 7);
        chk("t3_oe_cycles", 32'(oe_cnt), 12);
        chk("t3_rsp_err", 32'(rv_err), 0);
        chk("t3_rdata", 32'(rv_data), 'h1234);
        chk("t3_rsp_cycle", 32'(rv_off), 20);

        issue(1, 0, 1, 24'h000200, 16'h0000, 16'h5555, 1000);
        finish_txn();
        chk("t4_rsp_cycle", 32'(rv_off), 257);
        chk("t4_rsp_err", 32'(rv_err), 1);
        chk("t4_oe_cycles", 32'(oe_cnt), 0);
        chk("t4_rdata_held", 32'(rsp_rdata), 'h1234);

        issue(1, 1, 1, 24'h000300, 16'hAAAA, 16'h0000, 0);
        finish_txn();
        chk("t5_rsp_cycle", 32'(rv_off), 1);
        chk("t5_rsp_err", 32'(rv_err), 1);
        chk("t5_ce_cycles", 32'(ce_cnt), 0);

        issue(0, 1, 0, 24'h000020, 16'h12A5, 16'h0000, 0);
        finish_txn();
        chk("t6_we_cycles", 32'(we_cnt), 6);

        issue(0, 1, 1, 24'h000040, 16'hCAFE, 16'h0000, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        t_act = 0;
        @(posedge clk);
        #1;
        chk("t7_strobes_off", 32'({mem_we_n, mem_ram_ce_n, mem_lb_n, mem_ub_n, mem_dout_en}), 'b11110);
        rst = 1'b0;
        @(negedge clk);
        chk("t7_ready_after_rst", 32'(req_ready), 1);
        repeat (12) @(posedge clk);
        #1;

        issue(0, 0, 1, 24'h000080, 16'h0000, 16'hA1B2, 0);
        finish_txn();
        chk("t8_rdata", 32'(rv_data), 'hA1B2);
        chk("t8_oe_cycles", 32'(oe_cnt), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
